capture_ram_controller: RTL and testbench

//   Sequences one lattice_single_port_genram as a circular logic-analyser capture buffer.

---
 rtl/capture_ram_controller.sv | 103 ++++++++++
 tb/tb_capture_ram_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_ram_controller.sv
// capture_ram_controller: circular logic-analyser capture buffer sequencer for a single-port RAM.
module capture_ram_controller #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          trigger,
    input  logic [AW-1:0] post_count,
    output logic          busy,
    output logic          done,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRE     = 3'd1;
    localparam logic [2:0] POST    = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] RD_OUT  = 3'd5;
    localparam logic [AW:0] LEN_FULL = (AW+1)'(1) << AW;
    logic [2:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic          r_wrapped;
    logic [AW-1:0] r_remaining;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_len;
    logic          r_done;
    logic          w_write;
    logic          w_fin;
    logic          w_rd;
    logic [AW-1:0] w_wr_next;
    logic          w_wrap_next;
    assign w_write     = (r_state == PRE || r_state == POST) && sample_valid;
    assign w_wr_next   = r_wr_ptr + 1'b1;
    assign w_wrap_next = r_wrapped || (r_wr_ptr == {AW{1'b1}});
    // Last stored sample: trigger with no post samples, or the final post sample.
    assign w_fin = w_write && ((r_state == PRE && trigger && post_count == '0) ||
                               (r_state == POST && r_remaining == AW'(1)));
    assign w_rd      = r_state == RD_ADDR || r_state == RD_WAIT || r_state == RD_OUT;
    assign busy      = r_state != IDLE;
    assign done      = r_done;
    assign rd_valid  = r_state == RD_OUT;
    assign rd_last   = rd_valid && r_len == (AW+1)'(1);
    assign rd_data   = ram_rdata;
    assign ram_rw    = !w_write;
    assign ram_addr  = w_write ? r_wr_ptr : w_rd ? r_rd_ptr : '0;
    assign ram_wdata = w_write ? sample_data : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_wrapped   <= 1'b0;
            r_remaining <= '0;
            r_rd_ptr    <= '0;
            r_len       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_write) begin
                r_wr_ptr  <= w_wr_next;
                r_wrapped <= w_wrap_next;
            end
            if (w_fin) begin
                r_rd_ptr <= w_wrap_next ? w_wr_next : '0;
                r_len    <= w_wrap_next ? LEN_FULL : {1'b0, w_wr_next};
            end
            case (r_state)
                IDLE: if (arm) begin
                    r_state   <= PRE;
                    r_wr_ptr  <= '0;
                    r_wrapped <= 1'b0;
                end
                PRE: if (w_write && trigger) begin
                    r_remaining <= post_count;
                    r_state     <= post_count == '0 ? RD_ADDR : POST;
                end
                POST: if (w_write) begin
                    r_remaining <= r_remaining - 1'b1;
                    r_state     <= r_remaining == AW'(1) ? RD_ADDR : POST;
                end
                RD_ADDR: r_state <= RD_WAIT;
                RD_WAIT: r_state <= RD_OUT;
                RD_OUT: if (rd_ready) begin
                    r_state  <= rd_last ? IDLE : RD_ADDR;
                    r_done   <= rd_last;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_len    <= r_len - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_ram_controller.sv
// tb_capture_ram_controller: scoreboard bench with a RAM model and a sample-list reference model.
module tb_capture_ram_controller;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int SIZE = 1 << AW;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          trigger = 1'b0;
    logic [AW-1:0] post_count = '0;
    logic          busy, done, rd_valid, rd_last, ram_rw;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] mem [SIZE];
    logic [DW:0]   exp_q [$];
    int n_cmp = 0, n_err = 0, wr_cnt = 0, done_cnt = 0, ready_mode = 0;
    bit t3_stalled = 0, prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    capture_ram_controller #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .sample_valid(sample_valid),
        .sample_data(sample_data), .trigger(trigger), .post_count(post_count),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .ram_addr(ram_addr), .ram_rw(ram_rw),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ram_rw) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 2 && !t3_stalled && rd_valid && rd_data == 8'h03) begin
            t3_stalled = 1;
            rd_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            rd_ready = 1'b1;
        end else begin
            rd_ready = ready_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (!ram_rw) wr_cnt++;
            if (done) done_cnt++;
            if (prev_stall) begin
                n_cmp++;
                if (!rd_valid || rd_data !== prev_data) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid=%0b data=%0h want valid=1 data=%0h", rd_valid, rd_data, prev_data);
                end
            end
            if (rd_valid && rd_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL readout_extra: got last=%0b data=%0h want no word", rd_last, rd_data);
                end else begin
                    if ({rd_last, rd_data} !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL readout: got last=%0b data=%0h want last=%0b data=%0h",
                                 rd_last, rd_data, exp_q[0][DW], exp_q[0][DW-1:0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data = rd_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the stored samples are the first trig+post+1 valid samples; readout is the newest SIZE of them.
    task automatic run_capture(input logic [DW-1:0] smp[$], input int trig, input int post,
                               input bit gaps, input bit noise);
        int need = trig + post + 1;
        int first = need > SIZE ? need - SIZE : 0;
        int w0 = wr_cnt, d0 = done_cnt;
        for (int i = first; i < need; i++) exp_q.push_back({i == need - 1, smp[i]});
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < smp.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                sample_valid = 1'b0;
                trigger = 1'($urandom_range(0, 1));
                sample_data = DW'($urandom);
                tick();
            end
            sample_valid = 1'b1;
            sample_data = smp[i];
            trigger = i == trig;
            post_count = i == trig ? AW'(post) : AW'($urandom_range(0, SIZE - 1));
            arm = noise && i == need;
            tick();
            arm = 1'b0;
        end
        sample_valid = 1'b0;
        trigger = 1'b0;
        if (noise && smp.size() == need) begin
            arm = 1'b1;
            tick();
            arm = 1'b0;
        end
        for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clk);
        chk("done_seen", done_cnt != d0, 1);
        repeat (3) tick();
        chk("done_pulses", done_cnt - d0, 1);
        chk("idle_busy", busy, 0);
        chk("write_count", wr_cnt - w0, need);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        w0 = wr_cnt;
        repeat (4) begin
            sample_valid = 1'b1;
            sample_data = DW'($urandom);
            trigger = 1'($urandom_range(0, 1));
            tick();
        end
        sample_valid = 1'b0;
        trigger = 1'b0;
        chk("idle_no_write", wr_cnt - w0, 0);
        chk("idle_stays", busy, 0);
    endtask

    initial begin
        logic [DW-1:0] s[$];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_ram_rw", ram_rw, 1);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        reset = 1'b0;
        tick();
        s = {};
        for (int i = 0; i < 10; i++) s.push_back(DW'(i));
        run_capture(s, 5, 3, 0, 0);
        s = {};
        for (int i = 0; i < 40; i++) s.push_back(DW'(i));
        run_capture(s, 36, 3, 0, 0);
        ready_mode = 2;
        s = {};
        for (int i = 0; i < 10; i++) s.push_back(DW'(i));
        run_capture(s, 5, 3, 0, 0);
        chk("t3_stall_applied", t3_stalled, 1);
        ready_mode = 0;
        s = {8'hA5};
        run_capture(s, 0, 0, 0, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sample_valid = 1'b1;
            sample_data = DW'(8'h40 + i);
            trigger = i == 2;
            post_count = AW'(10);
            tick();
        end
        sample_valid = 1'b0;
        trigger = 1'b0;
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_ram_rw", ram_rw, 1);
        reset = 1'b0;
        tick();
        s = {};
        for (int i = 0; i < 10; i++) s.push_back(DW'(i));
        run_capture(s, 5, 3, 0, 0);
        run_capture(s, 5, 3, 1, 1);
        ready_mode = 1;
        repeat (20) begin
            int trig = $urandom_range(0, 40);
            int post = $urandom_range(0, SIZE - 1);
            int extra = $urandom_range(0, 3);
            s = {};
            for (int i = 0; i < trig + post + 1 + extra; i++) s.push_back(DW'($urandom));
            run_capture(s, trig, post, 1, 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
